glyph_stroke_plotter: RTL and testbench



---
 rtl/glyph_pkg.sv | 75 +++++++
 rtl/glyph_stroke_plotter_if.sv | 33 +++
 rtl/glyph_rom.sv | 18 +
 rtl/glyph_stroke_plotter.sv | 190 +++++++++++++++++++
 tb/tb_glyph_stroke_plotter.sv | 307 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/glyph_pkg.sv
// Shared types, direction encoding and the stroke table for glyph_stroke_plotter.
package glyph_pkg;

    localparam logic [2:0] DIR_E  = 3'd0;
    localparam logic [2:0] DIR_SE = 3'd1;
    localparam logic [2:0] DIR_S  = 3'd2;
    localparam logic [2:0] DIR_SW = 3'd3;
    localparam logic [2:0] DIR_W  = 3'd4;
    localparam logic [2:0] DIR_NW = 3'd5;
    localparam logic [2:0] DIR_N  = 3'd6;
    localparam logic [2:0] DIR_NE = 3'd7;

    typedef struct packed {
        logic signed [3:0] sx;
        logic signed [3:0] sy;
        logic [2:0]        dir;
        logic [3:0]        len;
    } seg_t;

    // Per-axis step: 2'b01 = +1, 2'b11 = -1, 2'b00 = 0.
    typedef struct packed {
        logic [1:0] dx;
        logic [1:0] dy;
    } delta_t;

    function automatic delta_t dir_delta(input logic [2:0] dir);
        delta_t d;
        d = '0;
        case (dir)
            DIR_E:   d = '{dx: 2'b01, dy: 2'b00};
            DIR_SE:  d = '{dx: 2'b01, dy: 2'b01};
            DIR_S:   d = '{dx: 2'b00, dy: 2'b01};
            DIR_SW:  d = '{dx: 2'b11, dy: 2'b01};
            DIR_W:   d = '{dx: 2'b11, dy: 2'b00};
            DIR_NW:  d = '{dx: 2'b11, dy: 2'b11};
            DIR_N:   d = '{dx: 2'b00, dy: 2'b11};
            default: d = '{dx: 2'b01, dy: 2'b11};
        endcase
        return d;
    endfunction

    function automatic int unsigned gs_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic seg_t mk_seg(input int sx, input int sy, input logic [2:0] dir,
                                    input int len);
        seg_t s;
        s.sx  = 4'(sx);
        s.sy  = 4'(sy);
        s.dir = dir;
        s.len = 4'(len);
        return s;
    endfunction

    localparam int unsigned TABLE_GLYPHS = 4;
    localparam int unsigned TABLE_SEGS   = 8;
    localparam seg_t        SEG_END      = '0;

    localparam seg_t GLYPH_TABLE [TABLE_GLYPHS][TABLE_SEGS] = '{
        // 0: L-corner
        '{mk_seg(0, 0, DIR_E, 4), mk_seg(0, 0, DIR_S, 5), SEG_END, SEG_END,
          SEG_END, SEG_END, SEG_END, SEG_END},
        // 1: diagonal
        '{mk_seg(0, 0, DIR_SE, 3), SEG_END, SEG_END, SEG_END,
          SEG_END, SEG_END, SEG_END, SEG_END},
        // 2: R outline
        '{mk_seg(0, 0, DIR_S, 7), mk_seg(1, 0, DIR_E, 3), mk_seg(4, 1, DIR_S, 2),
          mk_seg(1, 3, DIR_E, 3), mk_seg(2, 4, DIR_SE, 3), SEG_END, SEG_END, SEG_END},
        // 3: N outline
        '{mk_seg(0, 0, DIR_S, 7), mk_seg(1, 1, DIR_SE, 5), mk_seg(6, 0, DIR_S, 7),
          SEG_END, SEG_END, SEG_END, SEG_END, SEG_END}
    };

endpackage

// File: rtl/glyph_stroke_plotter_if.sv
// Request/pixel bundle between the game controller (master) and the plotter (slave).
interface glyph_stroke_plotter_if
    import glyph_pkg::*;
#(
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COL_W     = 3,
    parameter int unsigned NUM_GLYPH = 4
) ();
    localparam int unsigned GS_W = gs_width(NUM_GLYPH);

    logic             start;
    logic [GS_W-1:0]  glyph_sel;
    logic [X_W-1:0]   origin_x;
    logic [Y_W-1:0]   origin_y;
    logic [COL_W-1:0] colour_in;
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [COL_W-1:0] colour;
    logic             plot;
    logic             busy;
    logic             done;

    modport master (
        output start, glyph_sel, origin_x, origin_y, colour_in,
        input  x, y, colour, plot, busy, done
    );

    modport slave (
        input  start, glyph_sel, origin_x, origin_y, colour_in,
        output x, y, colour, plot, busy, done
    );
endinterface

// File: rtl/glyph_rom.sv
// Combinational stroke table lookup; out-of-range glyphs read as empty.
module glyph_rom
    import glyph_pkg::*;
#(
    parameter int unsigned NUM_GLYPH = 4,
    parameter int unsigned GS_W      = 2
) (
    input  logic [GS_W-1:0] glyph,
    input  logic [3:0]      seg,
    output seg_t            rec
);
    always_comb begin
        rec = SEG_END;
        if (32'(glyph) < NUM_GLYPH && 32'(glyph) < TABLE_GLYPHS && 32'(seg) < TABLE_SEGS) begin
            rec = GLYPH_TABLE[2'(glyph)][3'(seg)];
        end
    end
endmodule

// File: rtl/glyph_stroke_plotter.sv
// Table-driven stroke glyph plotter for vga_adapter, one pixel per TICK_DIV clocks.
// Define GLYPH_ERASE_EN to replay each glyph in colour 0 right after the draw pass.
module glyph_stroke_plotter
    import glyph_pkg::*;
#(
    parameter int unsigned X_W       = 8,
    parameter int unsigned Y_W       = 7,
    parameter int unsigned COL_W     = 3,
    parameter int unsigned TICK_DIV  = 3125000,
    parameter int unsigned MAX_SEG   = 8,
    parameter int unsigned NUM_GLYPH = 4
) (
    input logic                   clk,
    input logic                   reset,
    glyph_stroke_plotter_if.slave bus
);
    localparam int unsigned GS_W     = gs_width(NUM_GLYPH);
    localparam logic [24:0] DIV_LAST = 25'(TICK_DIV - 1);
    localparam logic [4:0]  SEG_LAST = 5'(MAX_SEG);

    typedef enum logic [2:0] {StIdle, StLoad, StStep, StNext, StFin} state_t;

    state_t           state_q;
    logic [GS_W-1:0]  glyph_q;
    logic [X_W-1:0]   ox_q, x_q, px_x;
    logic [Y_W-1:0]   oy_q, y_q, px_y;
    logic [COL_W-1:0] col_q, colour_q, px_col;
    logic [4:0]       seg_q;
    logic [3:0]       k_q, k_emit;
    logic [24:0]      div_q;
    logic             plot_q, busy_q, done_q;
    logic             div_wrap, last_px;
    seg_t             rec;
    delta_t           dl;

    glyph_rom #(
        .NUM_GLYPH(NUM_GLYPH),
        .GS_W     (GS_W)
    ) u_rom (
        .glyph(glyph_q),
        .seg  (seg_q[3:0]),
        .rec  (rec)
    );

    function automatic logic [X_W-1:0] walk_x(input logic [X_W-1:0] org,
                                              input logic [3:0] off, input logic [1:0] d,
                                              input logic [3:0] kk);
        logic [X_W-1:0] p, kext;
        p    = org + {{(X_W-4){off[3]}}, off};
        kext = {{(X_W-4){1'b0}}, kk};
        if (d == 2'b01) p = p + kext;
        else if (d == 2'b11) p = p - kext;
        return p;
    endfunction

    function automatic logic [Y_W-1:0] walk_y(input logic [Y_W-1:0] org,
                                              input logic [3:0] off, input logic [1:0] d,
                                              input logic [3:0] kk);
        logic [Y_W-1:0] p, kext;
        p    = org + {{(Y_W-4){off[3]}}, off};
        kext = {{(Y_W-4){1'b0}}, kk};
        if (d == 2'b01) p = p + kext;
        else if (d == 2'b11) p = p - kext;
        return p;
    endfunction

    assign dl       = dir_delta(rec.dir);
    assign div_wrap = (div_q == DIV_LAST);
    assign last_px  = (k_q == 4'(rec.len - 4'd1));
    // Step index of the pixel that the next registered plot (if any) will show.
    assign k_emit   = (state_q == StLoad) ? 4'd0 : (div_wrap ? k_q + 4'd1 : k_q);
    assign px_x     = walk_x(ox_q, rec.sx, dl.dx, k_emit);
    assign px_y     = walk_y(oy_q, rec.sy, dl.dy, k_emit);

`ifdef GLYPH_ERASE_EN
    logic pass_q;
    assign px_col = pass_q ? '0 : col_q;
`else
    assign px_col = col_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            glyph_q  <= '0;
            ox_q     <= '0;
            oy_q     <= '0;
            col_q    <= '0;
            seg_q    <= '0;
            k_q      <= '0;
            div_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef GLYPH_ERASE_EN
            pass_q   <= 1'b0;
`endif
        end else begin
            plot_q <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        glyph_q <= bus.glyph_sel;
                        ox_q    <= bus.origin_x;
                        oy_q    <= bus.origin_y;
                        col_q   <= bus.colour_in;
                        seg_q   <= '0;
                        busy_q  <= 1'b1;
`ifdef GLYPH_ERASE_EN
                        pass_q  <= 1'b0;
`endif
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    if (seg_q == SEG_LAST || rec.len == 4'd0) begin
`ifdef GLYPH_ERASE_EN
                        if (!pass_q) begin
                            pass_q <= 1'b1;
                            seg_q  <= '0;
                        end else begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= StFin;
                        end
`else
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StFin;
`endif
                    end else begin
                        k_q     <= '0;
                        div_q   <= '0;
                        state_q <= StStep;
                        if (DIV_LAST == '0) begin
                            plot_q   <= 1'b1;
                            x_q      <= px_x;
                            y_q      <= px_y;
                            colour_q <= px_col;
                        end
                    end
                end
                StStep: begin
                    if (div_wrap) begin
                        div_q <= '0;
                        if (last_px) begin
                            state_q <= StNext;
                        end else begin
                            k_q <= k_q + 4'd1;
                            if (DIV_LAST == '0) begin
                                plot_q   <= 1'b1;
                                x_q      <= px_x;
                                y_q      <= px_y;
                                colour_q <= px_col;
                            end
                        end
                    end else begin
                        div_q <= div_q + 25'd1;
                        if (div_q + 25'd1 == DIV_LAST) begin
                            plot_q   <= 1'b1;
                            x_q      <= px_x;
                            y_q      <= px_y;
                            colour_q <= px_col;
                        end
                    end
                end
                StNext: begin
                    seg_q   <= seg_q + 5'd1;
                    state_q <= StLoad;
                end
                StFin: begin
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.x      = x_q;
    assign bus.y      = y_q;
    assign bus.colour = colour_q;
    assign bus.plot   = plot_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_glyph_stroke_plotter.sv
// Scoreboard bench for glyph_stroke_plotter; expectations follow GLYPH_ERASE_EN when defined.
module tb_glyph_stroke_plotter;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

`ifdef GLYPH_ERASE_EN
    localparam int NPASS   = 2;
    localparam int EMPTY_N = 3;
`else
    localparam int NPASS   = 1;
    localparam int EMPTY_N = 2;
`endif
    localparam int BUDGET = 400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    pix_t exp_q[$];

    glyph_stroke_plotter_if #(.NUM_GLYPH(4)) if_a ();
    glyph_stroke_plotter_if #(.NUM_GLYPH(4)) if_b ();
    glyph_stroke_plotter_if #(.NUM_GLYPH(3)) if_c ();

    glyph_stroke_plotter #(.TICK_DIV(2), .NUM_GLYPH(4)) dut_a (
        .clk(clk), .reset(reset), .bus(if_a.slave));
    glyph_stroke_plotter #(.TICK_DIV(1), .NUM_GLYPH(4)) dut_b (
        .clk(clk), .reset(reset), .bus(if_b.slave));
    glyph_stroke_plotter #(.TICK_DIV(1), .NUM_GLYPH(3)) dut_c (
        .clk(clk), .reset(reset), .bus(if_c.slave));

    task automatic push_seg(input int ox, input int oy, input int sx, input int sy,
                            input int dx, input int dy, input int len, input int col);
        pix_t p;
        for (int k = 0; k < len; k++) begin
            p.x = 8'(ox + sx + k * dx);
            p.y = 7'(oy + sy + k * dy);
            p.c = 3'(col);
            exp_q.push_back(p);
        end
    endtask

    task automatic push_glyph(input int g, input int ox, input int oy, input int col);
        for (int pass = 0; pass < NPASS; pass++) begin
            int c;
            c = (pass == 0) ? col : 0;
            case (g)
                0: begin
                    push_seg(ox, oy, 0, 0, 1, 0, 4, c);
                    push_seg(ox, oy, 0, 0, 0, 1, 5, c);
                end
                1: push_seg(ox, oy, 0, 0, 1, 1, 3, c);
                3: begin
                    push_seg(ox, oy, 0, 0, 0, 1, 7, c);
                    push_seg(ox, oy, 1, 1, 1, 1, 5, c);
                    push_seg(ox, oy, 6, 0, 0, 1, 7, c);
                end
                default: ;
            endcase
        end
    endtask

    task automatic start_a(input int g, input int ox, input int oy, input int col);
        @(posedge clk); #1;
        if_a.glyph_sel = 2'(g); if_a.origin_x = 8'(ox); if_a.origin_y = 7'(oy);
        if_a.colour_in = 3'(col); if_a.start = 1'b1;
        @(posedge clk); #1;
        if_a.start = 1'b0;
    endtask

    task automatic start_b(input int g, input int ox, input int oy, input int col);
        @(posedge clk); #1;
        if_b.glyph_sel = 2'(g); if_b.origin_x = 8'(ox); if_b.origin_y = 7'(oy);
        if_b.colour_in = 3'(col); if_b.start = 1'b1;
        @(posedge clk); #1;
        if_b.start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++; if (if_a.x !== 8'd0) begin n_err++; $display("FAIL reset x: got %0d required 0", if_a.x); end
        n_cmp++; if (if_a.y !== 7'd0) begin n_err++; $display("FAIL reset y: got %0d required 0", if_a.y); end
        n_cmp++; if (if_a.colour !== 3'd0) begin n_err++; $display("FAIL reset colour: got %0d required 0", if_a.colour); end
        n_cmp++; if (if_a.plot !== 1'b0) begin n_err++; $display("FAIL reset plot: got %b required 0", if_a.plot); end
        n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL reset busy: got %b required 0", if_a.busy); end
        n_cmp++; if (if_a.done !== 1'b0) begin n_err++; $display("FAIL reset done: got %b required 0", if_a.done); end
    endtask

    task automatic test_l_corner();
        int n, plots, dones, first;
        pix_t e, got;
        exp_q.delete();
        push_glyph(0, 10, 20, 4);
        start_a(0, 10, 20, 4);
        n = 0; plots = 0; dones = 0; first = 0;
        while (dones == 0 && n < BUDGET) begin
            @(negedge clk); n++;
            if (if_a.plot) begin
                plots++;
                if (plots == 1) begin
                    first = n;
                    n_cmp++;
                    if (if_a.busy !== 1'b1) begin n_err++; $display("FAIL l_corner busy: got %b required 1", if_a.busy); end
                end
                got = {if_a.x, if_a.y, if_a.colour};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL l_corner extra plot: got x=%0d y=%0d required none", if_a.x, if_a.y);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL l_corner pixel %0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                                 plots, got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
            end
            if (if_a.done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL l_corner done: got %0d pulses required 1", dones); end
        n_cmp++; if (first !== 3) begin n_err++; $display("FAIL l_corner first plot cycle: got %0d required 3", first); end
        n_cmp++; if (plots !== 9 * NPASS) begin n_err++; $display("FAIL l_corner plot count: got %0d required %0d", plots, 9 * NPASS); end
        n_cmp++; if (if_a.busy !== 1'b0) begin n_err++; $display("FAIL l_corner busy at done: got %b required 0", if_a.busy); end
        @(negedge clk);
        n_cmp++; if (if_a.done !== 1'b0) begin n_err++; $display("FAIL l_corner done width: got %b required 0", if_a.done); end
    endtask

    task automatic test_back_to_back();
        int n, plots, dones, late;
        bit inj;
        pix_t e, got;
        exp_q.delete();
        push_glyph(0, 10, 20, 4);
        start_a(0, 10, 20, 4);
        n = 0; plots = 0; dones = 0; inj = 0;
        while (dones == 0 && n < BUDGET) begin
            @(negedge clk); n++;
            if (if_a.start) if_a.start = 1'b0;
            if (if_a.plot) begin
                plots++;
                got = {if_a.x, if_a.y, if_a.colour};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL b2b extra plot: got x=%0d y=%0d required none", if_a.x, if_a.y);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL b2b pixel %0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                                 plots, got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
                if (plots == 2 && !inj) begin
                    inj = 1;
                    if_a.glyph_sel = 2'd1; if_a.origin_x = 8'd50; if_a.origin_y = 7'd60;
                    if_a.colour_in = 3'd1; if_a.start = 1'b1;
                end
            end
            if (if_a.done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL b2b done: got %0d pulses required 1", dones); end
        n_cmp++; if (plots !== 9 * NPASS) begin n_err++; $display("FAIL b2b plot count: got %0d required %0d", plots, 9 * NPASS); end
        late = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (if_a.plot || if_a.busy) late++;
        end
        n_cmp++; if (late !== 0) begin n_err++; $display("FAIL b2b queued draw: got %0d active cycles required 0", late); end
    endtask

    task automatic test_reset_mid_draw();
        int n, plots, dones, first;
        pix_t e, got;
        exp_q.delete();
        push_glyph(0, 10, 20, 4);
        start_a(0, 10, 20, 4);
        n = 0; plots = 0; dones = 0;
        while (plots < 5 && n < BUDGET) begin
            @(negedge clk); n++;
            if (if_a.plot) begin
                plots++;
                got = {if_a.x, if_a.y, if_a.colour};
                e = exp_q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_err++;
                    $display("FAIL rst_mid pixel %0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                             plots, got.x, got.y, got.c, e.x, e.y, e.c);
                end
            end
            if (if_a.done) dones++;
        end
        reset = 1'b1;
        @(negedge clk);
        if (if_a.done) dones++;
        n_cmp++;
        if ({if_a.x, if_a.y, if_a.colour, if_a.plot, if_a.busy} !== '0) begin
            n_err++;
            $display("FAIL rst_mid outputs: got x=%0d y=%0d c=%0d plot=%b busy=%b required all 0",
                     if_a.x, if_a.y, if_a.colour, if_a.plot, if_a.busy);
        end
        n_cmp++; if (dones !== 0) begin n_err++; $display("FAIL rst_mid done: got %0d pulses required 0", dones); end
        reset = 1'b0;
        exp_q.delete();
        push_glyph(1, 30, 40, 2);
        start_a(1, 30, 40, 2);
        n = 0; plots = 0; dones = 0; first = 0;
        while (dones == 0 && n < BUDGET) begin
            @(negedge clk); n++;
            if (if_a.plot) begin
                plots++;
                if (plots == 1) first = n;
                got = {if_a.x, if_a.y, if_a.colour};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL rst_mid redraw extra plot: got x=%0d y=%0d required none", if_a.x, if_a.y);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL rst_mid redraw pixel %0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                                 plots, got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
            end
            if (if_a.done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL rst_mid redraw done: got %0d required 1", dones); end
        n_cmp++; if (first !== 3) begin n_err++; $display("FAIL rst_mid redraw first cycle: got %0d required 3", first); end
        n_cmp++; if (plots !== 3 * NPASS) begin n_err++; $display("FAIL rst_mid redraw count: got %0d required %0d", plots, 3 * NPASS); end
    endtask

    // Runs one glyph on the TICK_DIV=1 instance; first plot lands on cycle 2.
    task automatic test_fast_glyph(input int g, input int ox, input int oy, input int col,
                                   input int npix);
        int n, plots, dones, first;
        pix_t e, got;
        exp_q.delete();
        push_glyph(g, ox, oy, col);
        start_b(g, ox, oy, col);
        n = 0; plots = 0; dones = 0; first = 0;
        while (dones == 0 && n < BUDGET) begin
            @(negedge clk); n++;
            if (if_b.plot) begin
                plots++;
                if (plots == 1) first = n;
                got = {if_b.x, if_b.y, if_b.colour};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++; $display("FAIL glyph%0d extra plot: got x=%0d y=%0d required none", g, if_b.x, if_b.y);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_err++;
                        $display("FAIL glyph%0d pixel %0d: got (%0d,%0d,c%0d) required (%0d,%0d,c%0d)",
                                 g, plots, got.x, got.y, got.c, e.x, e.y, e.c);
                    end
                end
            end
            if (if_b.done) dones++;
        end
        n_cmp++; if (dones !== 1) begin n_err++; $display("FAIL glyph%0d done: got %0d required 1", g, dones); end
        n_cmp++; if (first !== 2) begin n_err++; $display("FAIL glyph%0d first cycle: got %0d required 2", g, first); end
        n_cmp++; if (plots !== npix * NPASS) begin n_err++; $display("FAIL glyph%0d count: got %0d required %0d", g, plots, npix * NPASS); end
    endtask

    task automatic test_empty_glyph();
        int n, plots, done_at;
        @(posedge clk); #1;
        if_c.glyph_sel = 2'd3; if_c.origin_x = 8'd5; if_c.origin_y = 7'd5;
        if_c.colour_in = 3'd7; if_c.start = 1'b1;
        @(posedge clk); #1;
        if_c.start = 1'b0;
        n = 0; plots = 0; done_at = 0;
        while (done_at == 0 && n < 50) begin
            @(negedge clk); n++;
            if (if_c.plot) plots++;
            if (if_c.done) done_at = n;
        end
        n_cmp++; if (plots !== 0) begin n_err++; $display("FAIL empty plots: got %0d required 0", plots); end
        n_cmp++; if (done_at !== EMPTY_N) begin n_err++; $display("FAIL empty done cycle: got %0d required %0d", done_at, EMPTY_N); end
    endtask

    initial begin
        if_a.start = 1'b0; if_a.glyph_sel = '0; if_a.origin_x = '0; if_a.origin_y = '0; if_a.colour_in = '0;
        if_b.start = 1'b0; if_b.glyph_sel = '0; if_b.origin_x = '0; if_b.origin_y = '0; if_b.colour_in = '0;
        if_c.start = 1'b0; if_c.glyph_sel = '0; if_c.origin_x = '0; if_c.origin_y = '0; if_c.colour_in = '0;
        repeat (3) @(posedge clk);
        test_reset();
        #1 reset = 1'b0;
        test_l_corner();
        test_back_to_back();
        test_reset_mid_draw();
        test_fast_glyph(1, 254, 126, 5, 3);
        test_fast_glyph(3, 20, 30, 7, 19);
        test_empty_glyph();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
